// File: rtl/io_btn_cond.sv
// io_btn_cond: conditions the raw active-low push-button pads for the core's
// memory-mapped i_io_btn input. Each button goes through a two-flop
// synchronizer and a debounce FSM. The result is a clean registered level,
// one-cycle press/release pulses and a sticky write-1-to-clear press flag.
//
// Ports (top):
//   i_clk            clock, all state on rising edge
//   i_rstn           async active-low reset
//   i_btn_raw[N]     raw pad levels, 0 = pressed, asynchronous to i_clk
//   i_clr_vld        one-cycle strobe qualifying i_clr_mask
//   i_clr_mask[N]    write-1-to-clear mask for o_press_flag
//   o_io_btn[N]      debounced level, active-low (idle = all ones)
//   o_press_pulse[N] one-cycle pulse on an accepted press
//   o_release_pulse[N] one-cycle pulse on an accepted release
//   o_press_flag[N]  sticky press flags

// Per-button synchronizer + debounce FSM.
module io_btn_cond_lane #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_lvl,
  output logic o_press,
  output logic o_release,
  output logic o_flag
);
  typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} st_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, s_q;
  st_e              state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             flag_q, flag_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      REL: if (!s_q) begin
        state_d = WAIT_P;
        cnt_d   = CNT_ONE;
      end
      WAIT_P: begin
        if (s_q) begin
          // bounce/glitch: back to idle without any event
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRS;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS: if (s_q) begin
        state_d = WAIT_R;
        cnt_d   = CNT_ONE;
      end
      WAIT_R: begin
        if (!s_q) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = REL;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
    // level follows the accepted state, registered alongside it
    lvl_d  = (state_d == REL) || (state_d == WAIT_P);
    // set wins over a same-cycle clear
    flag_d = (flag_q & ~i_clr) | press_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      state_q <= REL;
      cnt_q   <= '0;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      s_q     <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      flag_q  <= flag_d;
    end
  end

  assign o_lvl     = lvl_q;
  assign o_press   = press_q;
  assign o_release = rel_q;
  assign o_flag    = flag_q;
endmodule

module io_btn_cond #(
  parameter int NUM_BTN    = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  input  logic               i_clr_vld,
  input  logic [NUM_BTN-1:0] i_clr_mask,
  output logic [NUM_BTN-1:0] o_io_btn,
  output logic [NUM_BTN-1:0] o_press_pulse,
  output logic [NUM_BTN-1:0] o_release_pulse,
  output logic [NUM_BTN-1:0] o_press_flag
);
  logic [NUM_BTN-1:0] clr_bits;

  assign clr_bits = {NUM_BTN{i_clr_vld}} & i_clr_mask;

  io_btn_cond_lane #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_lane [NUM_BTN-1:0] (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_raw    (i_btn_raw),
    .i_clr    (clr_bits),
    .o_lvl    (o_io_btn),
    .o_press  (o_press_pulse),
    .o_release(o_release_pulse),
    .o_flag   (o_press_flag)
  );
endmodule

// File: doc/io_btn_cond.md
# io_btn_cond

Button conditioning front end that produces the `i_io_btn` value read by the pipelined core's memory-mapped input region. It takes the four raw, active-low, asynchronous push-button pads and passes each one through a two-flop synchronizer and a per-button debounce state machine. It then presents a clean active-low level to the core, plus sticky press-event flags with write-1-to-clear. It sits between the board pads and the core's `i_io_btn` port, so the core sees exactly the idle `4'b1111` and pressed `4'b0111`/`4'b1101` patterns the benches drive.

## Interface
- `NUM_BTN`, default 4: number of buttons; all per-button logic is replicated.
- `DEB_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a change. This is 10 ms at 50 MHz. Minimum legal value is 2.
- `CNT_W`, default `$clog2(DEB_CYCLES)`: debounce counter width.

Ports:
- `i_clk`, in, 1: single clock; all state updates on the rising edge.
- `i_rstn`, in, 1: asynchronous, active-low reset.
- `i_btn_raw`, in, `NUM_BTN`: raw pad levels; 0 = pressed; asynchronous to `i_clk`.
- `i_clr_vld`, in, 1: clear strobe for press flags, one cycle.
- `i_clr_mask`, in, `NUM_BTN`: write-1-to-clear mask, qualified by `i_clr_vld`.
- `o_io_btn`, out, `NUM_BTN`: debounced level, active-low; connects to core `i_io_btn`.
- `o_press_pulse`, out, `NUM_BTN`: one-cycle pulse on an accepted press (debounced 1→0).
- `o_release_pulse`, out, `NUM_BTN`: one-cycle pulse on an accepted release (debounced 0→1).
- `o_press_flag`, out, `NUM_BTN`: sticky press flag; set by press, cleared by mask write.

## Operation
- **Synchronizer:** two flops per bit, `sync1 <= i_btn_raw`, `s <= sync1`. Both reset to 1, meaning released.
- **Per-button FSM,** states `REL` (stable released), `WAIT_P`, `PRS` (stable pressed), `WAIT_R`, with counter `cnt`:
  - `REL`: if `s==0`, go to `WAIT_P` with `cnt=1`.
  - `WAIT_P`:
    - if `s==1`, return to `REL` with `cnt=0`; the glitch is rejected and there is no pulse.
    - else if `cnt==DEB_CYCLES-1`, go to `PRS`, drive the level to 0, assert `o_press_pulse` for one cycle and set the flag.
    - else `cnt++`.
  - `PRS`: if `s==1`, go to `WAIT_R` with `cnt=1`.
  - `WAIT_R`: mirror of `WAIT_P`.
    - if `s==0`, return to `PRS`.
    - else if `cnt==DEB_CYCLES-1`, go to `REL`, drive the level to 1 and assert `o_release_pulse`.
- **Level output:** `o_io_btn` is 1 in `REL`/`WAIT_P` and 0 in `PRS`/`WAIT_R`. It is registered, with no combinational path from `s`.
- **Press flags:**
  - next flag = (flag & ~(`i_clr_vld` ? `i_clr_mask` : 0)) | press_event.
  - Set wins over a same-cycle clear on the same bit.
- **Independence:** buttons are fully independent; simultaneous presses on several bits are each handled on their own counters.
- **Counter:** `cnt` never exceeds `DEB_CYCLES-1` and never wraps. It is held at 0 in stable states.

## Timing
- **Reset values** (asynchronous on `i_rstn==0`, held while low):
  - `o_io_btn = {NUM_BTN{1'b1}}`
  - `o_press_pulse = 0`, `o_release_pulse = 0`, `o_press_flag = 0`
  - all FSMs in `REL`, `cnt = 0`, synchronizer flops = 1.
- **Latency:** if the raw level first samples low at edge N and stays low, the following all update at edge N+`DEB_CYCLES`+1:
  - `o_io_btn` falls;
  - `o_press_pulse` is high for that cycle only;
  - `o_press_flag` is set.
  - Release timing is symmetric.
- **Glitch rejection:** a raw low pulse shorter than `DEB_CYCLES` synchronized samples produces no output change and no pulse or flag.
- **Clear timing:** a clear takes effect at the edge where `i_clr_vld` is sampled high; the flag reads 0 the next cycle.
- **Reset mid-debounce:** the FSM returns to `REL` immediately. After `i_rstn` rises, a still-held button requires the full `DEB_CYCLES`+2 cycles to be accepted again.
- **Held button:** exactly one press pulse per accepted press, regardless of hold length.

## Test plan
All scenarios use `DEB_CYCLES=4` and a 10 ns clock.
- **Reset:** assert `i_rstn=0` for 10 ns with `i_btn_raw=4'b0000` → `o_io_btn=4'b1111`, flags 0, no pulses during reset.
- **Press and hold:** from idle, drive `i_btn_raw=4'b0111` and hold →
  - `o_io_btn=4'b0111` exactly 5 edges after first sampling;
  - `o_press_pulse=4'b1000` for one cycle;
  - `o_press_flag=4'b1000`.
  - Releasing back to `4'b1111` → `o_release_pulse=4'b1000` 5 edges later.
- **Glitch rejection:** a 3-cycle low on bit 1 (`4'b1101`) → `o_io_btn` stays `4'b1111`; no pulse or flag.
- **Bounce:** on bit 0, drive low 2 cycles, high 1 cycle, then low steady → the press is accepted 5 edges after the final low edge; exactly one pulse.
- **Clear collision:**
  - A clear with mask `4'b1000` in the same cycle as a new bit-3 press → flag stays 1.
  - A clear with mask `4'b1010` in a quiet cycle → bits 3 and 1 cleared; other flags untouched.
- **Reset mid-debounce:** reset while bit 2 is in `WAIT_P` with the raw level held low → no pulse before reset. After reset, the press is accepted 5 edges after the first post-reset sample.
